// File: rtl/time_set_pkg.sv
// Shared types, limits and wrap helpers for the push-button time-setting front end.
package time_set_pkg;

  localparam int unsigned TIME_W = 6;

  localparam logic [TIME_W-1:0] HOURS_MAX  = 6'd23;
  localparam logic [TIME_W-1:0] MINSEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE    = 2'd0;
  localparam logic [1:0] FIELD_HOURS   = 2'd1;
  localparam logic [1:0] FIELD_MINUTES = 2'd2;
  localparam logic [1:0] FIELD_SECONDS = 2'd3;

  // Out-of-range values from the clock core are seeded as zero.
  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v,
                                                   input logic [TIME_W-1:0] max);
    return (v > max) ? '0 : v;
  endfunction

  function automatic logic [TIME_W-1:0] step_time(input logic [TIME_W-1:0] v,
                                                  input logic [TIME_W-1:0] max,
                                                  input logic              up);
    if (up) return (v >= max) ? '0 : v + 1'b1;
    else    return (v == '0) ? max : v - 1'b1;
  endfunction

endpackage

// File: rtl/time_set_input_debounce.sv
// One push button: 2-FF synchroniser, stability counter and one-cycle rising-edge press pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_a   <= btn_raw;
      sync_b   <= sync_a;
      stable_d <= stable;
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_b;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Both terms are registers, so the pulse is glitch-free and lasts one cycle.
  assign press = stable & ~stable_d;

endmodule

// File: rtl/time_set_input.sv
// Time-setting front end: debounced buttons drive a mode FSM that edits a copy of the current time.
module time_set_input
  import time_set_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [TIME_W-1:0] cur_hours,
  input  logic [TIME_W-1:0] cur_minutes,
  input  logic [TIME_W-1:0] cur_seconds,
  output logic [TIME_W-1:0] set_hours,
  output logic [TIME_W-1:0] set_minutes,
  output logic [TIME_W-1:0] set_seconds,
  output logic              load,
  output logic              editing,
  output logic [1:0]        field,
  output logic [2:0]        btn_oeb
);

  logic   p_mode;
  logic   p_inc;
  logic   p_dec;
  state_t state;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_mode), .press(p_mode)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_inc), .press(p_inc)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_dec), .press(p_dec)
  );

  assign btn_oeb = 3'b111;

  // editing/field are assigned alongside every state change so they stay registered and aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      set_hours   <= '0;
      set_minutes <= '0;
      set_seconds <= '0;
      load        <= 1'b0;
      editing     <= 1'b0;
      field       <= FIELD_NONE;
    end else begin
      load <= 1'b0;
      if (p_mode) begin
        unique case (state)
          RUN: begin
            state       <= SET_H;
            editing     <= 1'b1;
            field       <= FIELD_HOURS;
            set_hours   <= clamp_time(cur_hours, HOURS_MAX);
            set_minutes <= clamp_time(cur_minutes, MINSEC_MAX);
            set_seconds <= clamp_time(cur_seconds, MINSEC_MAX);
          end
          SET_H: begin
            state <= SET_M;
            field <= FIELD_MINUTES;
          end
          SET_M: begin
            state <= SET_S;
            field <= FIELD_SECONDS;
          end
          SET_S: begin
            state   <= RUN;
            editing <= 1'b0;
            field   <= FIELD_NONE;
            load    <= 1'b1;
          end
          default: state <= RUN;
        endcase
      end else if (p_inc ^ p_dec) begin
        unique case (state)
          SET_H:   set_hours   <= step_time(set_hours, HOURS_MAX, p_inc);
          SET_M:   set_minutes <= step_time(set_minutes, MINSEC_MAX, p_inc);
          SET_S:   set_seconds <= step_time(set_seconds, MINSEC_MAX, p_inc);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_time_set_input.sv
// Randomised and directed checks of time_set_input against a behavioural model of the button UI.
module tb_time_set_input;

  localparam int D    = 4;
  localparam int HOLD = D + 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [5:0] cur_hours = '0, cur_minutes = '0, cur_seconds = '0;
  logic [5:0] set_hours, set_minutes, set_seconds;
  logic       load, editing;
  logic [1:0] field;
  logic [2:0] btn_oeb;

  time_set_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .load(load), .editing(editing), .field(field), .btn_oeb(btn_oeb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // load monitor: counts high cycles and records the time presented with each pulse
  int load_cnt = 0;
  int ld_h = 0, ld_m = 0, ld_s = 0;
  always @(negedge clk) begin
    if (load !== 1'b0) begin
      load_cnt++;
      ld_h = set_hours;
      ld_m = set_minutes;
      ld_s = set_seconds;
    end
  end

  // reference model: mode index 0=run,1=hours,2=minutes,3=seconds
  int m_st = 0, m_h = 0, m_m = 0, m_s = 0;
  int exp_loads = 0;
  int exp_ld_h = 0, exp_ld_m = 0, exp_ld_s = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_apply(input bit mo, input bit in, input bit de);
    if (mo) begin
      if (m_st == 0) begin
        m_h  = (cur_hours   > 23) ? 0 : int'(cur_hours);
        m_m  = (cur_minutes > 59) ? 0 : int'(cur_minutes);
        m_s  = (cur_seconds > 59) ? 0 : int'(cur_seconds);
        m_st = 1;
      end else if (m_st == 3) begin
        m_st = 0;
        exp_loads++;
        exp_ld_h = m_h; exp_ld_m = m_m; exp_ld_s = m_s;
      end else begin
        m_st++;
      end
    end else if (m_st != 0 && in != de) begin
      case (m_st)
        1: m_h = in ? (m_h + 1) % 24 : (m_h + 23) % 24;
        2: m_m = in ? (m_m + 1) % 60 : (m_m + 59) % 60;
        default: m_s = in ? (m_s + 1) % 60 : (m_s + 59) % 60;
      endcase
    end
  endtask

  task automatic press(input bit mo, input bit in, input bit de);
    @(negedge clk);
    btn_mode = mo; btn_inc = in; btn_dec = de;
    repeat (HOLD) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_apply(mo, in, de);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hours"},   set_hours,   m_h);
    check({tag, ".minutes"}, set_minutes, m_m);
    check({tag, ".seconds"}, set_seconds, m_s);
    check({tag, ".editing"}, editing,     (m_st != 0) ? 1 : 0);
    check({tag, ".field"},   field,       m_st);
    check({tag, ".loads"},   load_cnt,    exp_loads);
    if (exp_loads > 0) begin
      check({tag, ".ld_h"}, ld_h, exp_ld_h);
      check({tag, ".ld_m"}, ld_m, exp_ld_m);
      check({tag, ".ld_s"}, ld_s, exp_ld_s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int loads_before;
    int r;

    // 1. reset values
    repeat (3) @(negedge clk);
    check("rst.load", load, 0);
    check("rst.editing", editing, 0);
    check("rst.field", field, 0);
    check("rst.hours", set_hours, 0);
    check("rst.minutes", set_minutes, 0);
    check("rst.seconds", set_seconds, 0);
    check("rst.oeb", btn_oeb, 3'b111);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 3. capture 23:59:58
    cur_hours = 6'd23; cur_minutes = 6'd59; cur_seconds = 6'd58;
    press(1, 0, 0);
    check("t3.editing", editing, 1);
    check("t3.field", field, 1);
    check("t3.hours", set_hours, 23);
    check("t3.minutes", set_minutes, 59);
    check("t3.seconds", set_seconds, 58);

    // 2. short glitch is rejected
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (2) @(negedge clk);
    btn_inc = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("glitch.hours", set_hours, 23);

    // 2. long press: change lands on the 7th edge after the rise, exactly once
    @(negedge clk);
    btn_inc = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) check("lat.before", set_hours, 23);
      if (k == 7) check("lat.edge", set_hours, 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_inc = 1'b0;
    repeat (HOLD) @(negedge clk);
    model_apply(0, 1, 0);
    check("inc_once.hours", set_hours, 0);
    check_all("t3.inc");

    press(0, 0, 1);
    check("t3.dec.hours", set_hours, 23);

    // 4. minutes wrap then load
    press(1, 0, 0);
    check("t4.field_m", field, 2);
    press(0, 1, 0);
    check("t4.min_wrap", set_minutes, 0);
    press(0, 1, 0);
    check("t4.min_one", set_minutes, 1);
    press(1, 0, 0);
    check("t4.field_s", field, 3);
    press(1, 0, 0);
    check("t4.load_once", load_cnt, 1);
    check("t4.ld_h", ld_h, 23);
    check("t4.ld_m", ld_m, 1);
    check("t4.ld_s", ld_s, 58);
    check("t4.editing", editing, 0);
    check_all("t4");

    // 5. out-of-range capture and simultaneous buttons
    cur_hours = 6'd30; cur_minutes = 6'd10; cur_seconds = 6'd20;
    press(1, 0, 0);
    check("t5.clamp_h", set_hours, 0);
    check("t5.min", set_minutes, 10);
    press(1, 1, 0);
    check("t5.mode_wins.field", field, 2);
    check("t5.mode_wins.hours", set_hours, 0);
    check("t5.mode_wins.min", set_minutes, 10);
    press(0, 1, 1);
    check("t5.incdec.min", set_minutes, 10);
    press(1, 0, 0);
    press(1, 0, 0);
    check_all("t5");

    // randomised sequence against the model
    for (int i = 0; i < 40; i++) begin
      if (m_st == 0 && $urandom_range(0, 1) == 1) begin
        cur_hours   = 6'($urandom_range(0, 31));
        cur_minutes = 6'($urandom_range(0, 63));
        cur_seconds = 6'($urandom_range(0, 63));
      end
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: press(1, 0, 0);
        3, 4, 5: press(0, 1, 0);
        6, 7:    press(0, 0, 1);
        8:       press(0, 1, 1);
        default: press(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      endcase
      check_all($sformatf("rnd%0d", i));
    end

    // 6. reset while editing minutes
    for (int k = 0; k < 4 && m_st != 2; k++) press(1, 0, 0);
    check("t6.field_m", field, 2);
    loads_before = load_cnt;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6.editing", editing, 0);
    check("t6.field", field, 0);
    check("t6.hours", set_hours, 0);
    check("t6.minutes", set_minutes, 0);
    check("t6.seconds", set_seconds, 0);
    check("t6.load", load, 0);
    check("t6.oeb", btn_oeb, 3'b111);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_st = 0; m_h = 0; m_m = 0; m_s = 0;
    repeat (HOLD) @(negedge clk);
    check("t6.no_load", load_cnt, loads_before);
    check("t6.field_after", field, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
